// File: rtl/tge_rx_bad_frame_counter.sv
// Bad receive frame counter for the TGE RX interface, read back through the rxbadctr register.
// Define TGE_RXBAD_SATURATE_EN to make the count stick at its maximum instead of wrapping.
module tge_rx_bad_frame_counter #(
    parameter int CTR_WIDTH       = 32,
    parameter int MIN_FRAME_WORDS = 8
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic        rx_valid,
    input  logic        rx_eof,
    input  logic        rx_bad_frame,
    input  logic        rx_overrun,
    input  logic        ctr_en,
    input  logic        ctr_rst,
    output logic [31:0] user_data_out,
    output logic        bad_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [15:0]            word_cnt;
    logic [15:0]            word_cnt_nxt;
    logic [15:0]            word_inc;
    logic                   runt;
    logic                   bad_event;
    logic                   ctr_rst_d;
    logic                   clr;
    logic [CTR_WIDTH-1:0]   count;
    logic [CTR_WIDTH-1:0]   count_inc;

    // word_cnt is always 0 in IDLE, so word_inc doubles as the single-word frame length there.
    always_comb begin
        word_inc = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
        runt     = ({16'd0, word_inc} < 32'(MIN_FRAME_WORDS));
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        bad_event    = 1'b0;
        case (state)
            IDLE: begin
                bad_event = rx_overrun | (rx_valid & rx_eof & (rx_bad_frame | runt));
                if (rx_valid && !rx_eof) begin
                    state_nxt    = FRAME;
                    word_cnt_nxt = 16'd1;
                end
            end
            FRAME: begin
                if (rx_overrun) begin
                    // An overrun landing on the eof word closes the frame instead of swallowing the next one.
                    bad_event = 1'b1;
                    if (rx_valid && rx_eof) begin
                        state_nxt    = IDLE;
                        word_cnt_nxt = 16'd0;
                    end else begin
                        state_nxt    = DROP;
                        word_cnt_nxt = rx_valid ? word_inc : word_cnt;
                    end
                end else if (rx_valid) begin
                    if (rx_eof) begin
                        bad_event    = rx_bad_frame | runt;
                        state_nxt    = IDLE;
                        word_cnt_nxt = 16'd0;
                    end else begin
                        word_cnt_nxt = word_inc;
                    end
                end
            end
            DROP: begin
                if (rx_valid && rx_eof) begin
                    state_nxt    = IDLE;
                    word_cnt_nxt = 16'd0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                word_cnt_nxt = 16'd0;
            end
        endcase
    end

    always_comb begin
        clr = ctr_rst & ~ctr_rst_d;
`ifdef TGE_RXBAD_SATURATE_EN
        count_inc = (&count) ? count : count + CTR_WIDTH'(1);
`else
        count_inc = count + CTR_WIDTH'(1);
`endif
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state         <= IDLE;
            word_cnt      <= 16'd0;
            ctr_rst_d     <= 1'b0;
            count         <= '0;
            bad_pulse     <= 1'b0;
            user_data_out <= 32'd0;
        end else begin
            state         <= state_nxt;
            word_cnt      <= word_cnt_nxt;
            ctr_rst_d     <= ctr_rst;
            bad_pulse     <= bad_event & ctr_en;
            // Clear beats a coincident event; the strobe still reports the event.
            if (clr) begin
                count <= '0;
            end else if (bad_event && ctr_en) begin
                count <= count_inc;
            end
            user_data_out <= 32'(count);
        end
    end

endmodule

// File: tb/tb_tge_rx_bad_frame_counter.sv
// Directed bench for tge_rx_bad_frame_counter: a 32-bit and a 4-bit counter share one stimulus stream.
module tb_tge_rx_bad_frame_counter;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic        rx_eof;
    logic        rx_bad_frame;
    logic        rx_overrun;
    logic        ctr_en;
    logic        ctr_rst;
    logic [31:0] udo32;
    logic [31:0] udo4;
    logic        bp32;
    logic        bp4;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses32 = 0;
    int pulses4  = 0;

    tge_rx_bad_frame_counter #(.CTR_WIDTH(32), .MIN_FRAME_WORDS(8)) dut32 (
        .user_clk(clk), .user_rst_n(rst_n), .rx_valid(rx_valid), .rx_eof(rx_eof),
        .rx_bad_frame(rx_bad_frame), .rx_overrun(rx_overrun), .ctr_en(ctr_en),
        .ctr_rst(ctr_rst), .user_data_out(udo32), .bad_pulse(bp32)
    );

    tge_rx_bad_frame_counter #(.CTR_WIDTH(4), .MIN_FRAME_WORDS(8)) dut4 (
        .user_clk(clk), .user_rst_n(rst_n), .rx_valid(rx_valid), .rx_eof(rx_eof),
        .rx_bad_frame(rx_bad_frame), .rx_overrun(rx_overrun), .ctr_en(ctr_en),
        .ctr_rst(ctr_rst), .user_data_out(udo4), .bad_pulse(bp4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes are counted at the edge after they rise, so snapshots taken at negedge never race.
    always @(posedge clk) begin
        if (bp32) pulses32++;
        if (bp4)  pulses4++;
    end

    typedef struct {
        int          len;
        bit          bad;
        int          ovr_at;
        bit          ovr_again;
        bit          en;
        logic [31:0] exp_count;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp4(input logic [31:0] e);
`ifdef TGE_RXBAD_SATURATE_EN
        return (e > 32'd15) ? 32'd15 : e;
`else
        return e & 32'hF;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid     = 1'b0;
            rx_eof       = 1'b0;
            rx_bad_frame = 1'b0;
            rx_overrun   = 1'b0;
        end
    endtask

    // len 0 means a lone overrun cycle with no frame in flight.
    task automatic send_frame(input int len, input bit bad, input int ovr_at,
                              input bit ovr_again, input bit clr_on_eof);
        if (len == 0) begin
            @(negedge clk);
            rx_valid     = 1'b0;
            rx_eof       = 1'b0;
            rx_bad_frame = 1'b0;
            rx_overrun   = 1'b1;
        end else begin
            for (int i = 1; i <= len; i++) begin
                @(negedge clk);
                rx_valid     = 1'b1;
                rx_eof       = (i == len);
                rx_bad_frame = (i == len) && bad;
                rx_overrun   = (i == ovr_at) || (ovr_again && (i == ovr_at + 2));
                if (clr_on_eof && i == len) ctr_rst = 1'b1;
            end
        end
    endtask

    initial begin
        int p32;
        int p4;

        vecs[0]  = '{5,  1'b0, 0, 1'b0, 1'b1, 32'd2, 1};
        vecs[1]  = '{8,  1'b0, 0, 1'b0, 1'b1, 32'd2, 0};
        vecs[2]  = '{1,  1'b0, 0, 1'b0, 1'b1, 32'd3, 1};
        vecs[3]  = '{7,  1'b0, 0, 1'b0, 1'b1, 32'd4, 1};
        vecs[4]  = '{10, 1'b1, 4, 1'b1, 1'b1, 32'd5, 1};
        vecs[5]  = '{0,  1'b0, 0, 1'b0, 1'b1, 32'd6, 1};
        vecs[6]  = '{10, 1'b1, 0, 1'b0, 1'b0, 32'd6, 0};
        vecs[7]  = '{10, 1'b1, 0, 1'b0, 1'b0, 32'd6, 0};
        vecs[8]  = '{10, 1'b1, 0, 1'b0, 1'b0, 32'd6, 0};
        vecs[9]  = '{10, 1'b1, 0, 1'b0, 1'b0, 32'd6, 0};
        vecs[10] = '{10, 1'b1, 0, 1'b0, 1'b1, 32'd7, 1};

        rst_n        = 1'b0;
        rx_valid     = 1'b0;
        rx_eof       = 1'b0;
        rx_bad_frame = 1'b0;
        rx_overrun   = 1'b0;
        ctr_en       = 1'b1;
        ctr_rst      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_udo32", udo32, 32'd0);
        check("reset_udo4", udo4, 32'd0);
        check("reset_bp32", {31'd0, bp32}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Three 10-word frames, bad flag on the second eof; check exact latency
        p32 = pulses32;
        send_frame(10, 1'b0, 0, 1'b0, 1'b0);
        idle(3);
        check("t1_good_frame", udo32, 32'd0);
        send_frame(10, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        check("t1_pulse_at_plus1", {31'd0, bp32}, 32'd1);
        check("t1_udo_not_yet", udo32, 32'd0);
        idle(1);
        check("t1_udo_at_plus2", udo32, 32'd1);
        check("t1_pulse_one_cycle", {31'd0, bp32}, 32'd0);
        send_frame(10, 1'b0, 0, 1'b0, 1'b0);
        idle(3);
        check("t1_count", udo32, 32'd1);
        check("t1_pulses", 32'(pulses32 - p32), 32'd1);

        // Table: runts, boundaries, overruns, enable gating
        for (int v = 0; v < 11; v++) begin
            ctr_en = vecs[v].en;
            p32 = pulses32;
            p4  = pulses4;
            send_frame(vecs[v].len, vecs[v].bad, vecs[v].ovr_at, vecs[v].ovr_again, 1'b0);
            idle(3);
            check($sformatf("vec%0d_udo32", v), udo32, vecs[v].exp_count);
            check($sformatf("vec%0d_udo4", v), udo4, exp4(vecs[v].exp_count));
            check($sformatf("vec%0d_pulses32", v), 32'(pulses32 - p32), 32'(vecs[v].exp_pulses));
            check($sformatf("vec%0d_pulses4", v), 32'(pulses4 - p4), 32'(vecs[v].exp_pulses));
        end
        ctr_en = 1'b1;

        // Clear rising with a bad eof: clear wins, strobe still fires
        send_frame(10, 1'b1, 0, 1'b0, 1'b1);
        idle(1);
        check("t4_clr_pulse", {31'd0, bp32}, 32'd1);
        idle(2);
        check("t4_clr_udo32", udo32, 32'd0);
        check("t4_clr_udo4", udo4, 32'd0);
        // Clear held high does not re-clear
        send_frame(10, 1'b1, 0, 1'b0, 1'b0);
        idle(40);
        send_frame(10, 1'b1, 0, 1'b0, 1'b0);
        idle(40);
        check("t4_hold_udo32", udo32, 32'd2);
        check("t4_hold_udo4", udo4, 32'd2);
        ctr_rst = 1'b0;
        idle(2);

        // Drive the 4-bit counter to its top, then one more bad frame
        repeat (13) begin
            send_frame(1, 1'b1, 0, 1'b0, 1'b0);
            idle(1);
        end
        idle(3);
        check("t6_at15_udo32", udo32, 32'd15);
        check("t6_at15_udo4", udo4, 32'd15);
        p4 = pulses4;
        send_frame(1, 1'b1, 0, 1'b0, 1'b0);
        idle(3);
        check("t6_top_udo32", udo32, 32'd16);
        check("t6_top_udo4", udo4, exp4(32'd16));
        check("t6_top_pulse4", 32'(pulses4 - p4), 32'd1);

        // Asynchronous reset mid-frame, then the tail of that frame is a 4-word runt
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_eof   = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_udo32", udo32, 32'd0);
        check("t6_async_udo4", udo4, 32'd0);
        check("t6_async_bp32", {31'd0, bp32}, 32'd0);
        check("t6_async_bp4", {31'd0, bp4}, 32'd0);
        idle(1);
        rst_n = 1'b1;
        send_frame(4, 1'b0, 0, 1'b0, 1'b0);
        idle(3);
        check("t6_tail_runt_udo32", udo32, 32'd1);
        check("t6_tail_runt_udo4", udo4, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
